lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lock_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// Two-gate boat lock sequencer: levels the pound, cycles the entry and exit gates
// with acknowledge timeouts, and latches a sticky fault if a gate fails to respond.
module lock_ctrl #(
   parameter int GATE_TIMEOUT = 16,
   parameter int SETTLE       = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic fiveMinTillArriv,
   input  logic dir,
   input  logic poundOccu,
   input  logic diffOk0,
   input  logic diffOk1,
   input  logic doorOpen0,
   input  logic doorOpen1,
   output logic ctrl0,
   output logic ctrl1,
   output logic fill,
   output logic drain,
   output logic busy,
   output logic fault
);

   localparam int MAX_CNT = (GATE_TIMEOUT > SETTLE) ? GATE_TIMEOUT : SETTLE;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] CNT_MAX     = CW'(MAX_CNT);
   localparam logic [CW-1:0] GATE_LAST   = CW'(GATE_TIMEOUT - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      PREP     = 4'd1,
      OPEN_A   = 4'd2,
      ENTER    = 4'd3,
      CLOSE_A  = 4'd4,
      ADJUST   = 4'd5,
      SETTLE_W = 4'd6,
      OPEN_B   = 4'd7,
      EXIT     = 4'd8,
      CLOSE_B  = 4'd9,
      FAULT    = 4'd10
   } state_t;

   state_t          state_r, state_s;
   logic            dir_r, dir_s;
   logic [CW-1:0]   gate_cnt_r, gate_cnt_s;
   logic [CW-1:0]   settle_cnt_r, settle_cnt_s;
   logic            ctrl0_s, ctrl1_s, fill_s, drain_s, busy_s, fault_s;
   logic            a_ok_s, b_ok_s, a_open_s, b_open_s, a_ok_nxt_s;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      sat_inc = (v >= CNT_MAX) ? v : v + CW'(1);
   endfunction

   // Gate A is the entry side selected by the latched direction; B is the far side.
   assign a_ok_s     = dir_r ? diffOk1   : diffOk0;
   assign b_ok_s     = dir_r ? diffOk0   : diffOk1;
   assign a_open_s   = dir_r ? doorOpen1 : doorOpen0;
   assign b_open_s   = dir_r ? doorOpen0 : doorOpen1;
   assign a_ok_nxt_s = dir_s ? diffOk1   : diffOk0;

   // Next-state, counter and next-output logic.
   always_comb begin
      state_s      = state_r;
      dir_s        = dir_r;
      gate_cnt_s   = '0;
      settle_cnt_s = '0;
      case (state_r)
         IDLE: begin
            if (fiveMinTillArriv && !poundOccu) begin
               state_s = PREP;
               dir_s   = dir;
            end else begin
               state_s = IDLE;
            end
         end
         PREP:    state_s = a_ok_s    ? OPEN_A  : PREP;
         ENTER:   state_s = poundOccu ? CLOSE_A : ENTER;
         ADJUST:  state_s = b_ok_s    ? SETTLE_W : ADJUST;
         EXIT:    state_s = poundOccu ? EXIT    : CLOSE_B;
         OPEN_A, CLOSE_A, OPEN_B, CLOSE_B: begin
            // Acknowledge is tested before the timeout so an ack on the limit cycle wins.
            if ((state_r == OPEN_A  &&  a_open_s) || (state_r == CLOSE_A && !a_open_s) ||
                (state_r == OPEN_B  &&  b_open_s) || (state_r == CLOSE_B && !b_open_s)) begin
               case (state_r)
                  OPEN_A:  state_s = ENTER;
                  CLOSE_A: state_s = ADJUST;
                  OPEN_B:  state_s = EXIT;
                  default: state_s = IDLE;
               endcase
            end else if (gate_cnt_r >= GATE_LAST) begin
               state_s = FAULT;
            end else begin
               gate_cnt_s = sat_inc(gate_cnt_r);
            end
         end
         SETTLE_W: begin
            if (!b_ok_s) begin
               state_s = ADJUST;
            end else if (settle_cnt_r >= SETTLE_LAST) begin
               state_s = OPEN_B;
            end else begin
               settle_cnt_s = sat_inc(settle_cnt_r);
            end
         end
         FAULT:   state_s = FAULT;
         default: state_s = FAULT;
      endcase

      ctrl0_s = 1'b0;
      ctrl1_s = 1'b0;
      fill_s  = 1'b0;
      drain_s = 1'b0;
      fault_s = 1'b0;
      busy_s  = (state_s != IDLE) && (state_s != FAULT);
      case (state_s)
         PREP: begin
            fill_s  =  dir_s & ~a_ok_nxt_s;
            drain_s = ~dir_s & ~a_ok_nxt_s;
         end
         OPEN_A, ENTER: begin
            ctrl0_s = ~dir_s;
            ctrl1_s =  dir_s;
         end
         ADJUST: begin
            fill_s  = ~dir_s;
            drain_s =  dir_s;
         end
         OPEN_B, EXIT: begin
            ctrl0_s =  dir_s;
            ctrl1_s = ~dir_s;
         end
         FAULT:   fault_s = 1'b1;
         default: fault_s = 1'b0;
      endcase
   end

   // State, counters and registered Moore outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         dir_r        <= 1'b0;
         gate_cnt_r   <= '0;
         settle_cnt_r <= '0;
         ctrl0        <= 1'b0;
         ctrl1        <= 1'b0;
         fill         <= 1'b0;
         drain        <= 1'b0;
         busy         <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state_r      <= state_s;
         dir_r        <= dir_s;
         gate_cnt_r   <= gate_cnt_s;
         settle_cnt_r <= settle_cnt_s;
         ctrl0        <= ctrl0_s;
         ctrl1        <= ctrl1_s;
         fill         <= fill_s;
         drain        <= drain_s;
         busy         <= busy_s;
         fault        <= fault_s;
      end
   end

endmodule

// File: tb/tb_lock_ctrl.sv
// Scoreboard bench for lock_ctrl: stimulus queues hand-computed output vectors,
// a negedge monitor pops and compares them and checks the safety invariants.
module tb_lock_ctrl;
   logic clk = 1'b0;
   logic reset, fiveMinTillArriv, dir, poundOccu, diffOk0, diffOk1, doorOpen0, doorOpen1;
   logic ctrl0, ctrl1, fill, drain, busy, fault;

   lock_ctrl #(.GATE_TIMEOUT(16), .SETTLE(8)) dut (
      .clk(clk), .reset(reset), .fiveMinTillArriv(fiveMinTillArriv), .dir(dir),
      .poundOccu(poundOccu), .diffOk0(diffOk0), .diffOk1(diffOk1),
      .doorOpen0(doorOpen0), .doorOpen1(doorOpen1),
      .ctrl0(ctrl0), .ctrl1(ctrl1), .fill(fill), .drain(drain), .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   // Output vector {ctrl0, ctrl1, fill, drain, busy, fault}
   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_BUSY  = 6'b000010;
   localparam logic [5:0] O_C0    = 6'b100010;
   localparam logic [5:0] O_C1    = 6'b010010;
   localparam logic [5:0] O_FILL  = 6'b001010;
   localparam logic [5:0] O_DRAIN = 6'b000110;
   localparam logic [5:0] O_FAULT = 6'b000001;

   typedef struct {
      int         due;
      logic [5:0] val;
      string      tag;
   } exp_t;

   exp_t q[$];
   int cyc = 0;
   int errors = 0;
   int checks = 0;
   logic [5:0] act;
   assign act = {ctrl0, ctrl1, fill, drain, busy, fault};

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due this cycle, then the invariants.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         checks++;
         if (e.due != cyc || act !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b (due %0d, cycle %0d)", e.tag, act, e.val, e.due, cyc);
         end
      end
      checks++;
      if ((ctrl0 & ctrl1) | (fill & drain) | ((fill | drain) & (ctrl0 | ctrl1))) begin
         errors++;
         $display("FAIL invariant: got outputs %b, required no gate overlap and no flow with a gate open (cycle %0d)", act, cyc);
      end
   end

   // Inputs set before the call are sampled at the next edge; e is the output after it.
   task automatic cyc_exp(input logic [5:0] e, input string tag);
      q.push_back('{due: cyc + 1, val: e, tag: tag});
      @(posedge clk);
      #1;
   endtask

   task automatic exp_now(input logic [5:0] e, input string tag);
      #1;
      q.push_back('{due: cyc, val: e, tag: tag});
   endtask

   task automatic cyc_nc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      fiveMinTillArriv = 1'b0; dir = 1'b0; poundOccu = 1'b0;
      diffOk0 = 1'b0; diffOk1 = 1'b0; doorOpen0 = 1'b0; doorOpen1 = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      quiet_inputs();
      repeat (2) @(posedge clk);
      #1;
      exp_now(O_IDLE, "reset_state");
      cyc_nc();
      reset = 1'b1;
      cyc_exp(O_IDLE, "idle_after_reset");

      // dir=0, level already matches side 0; fill 5 cycles, settle 8.
      diffOk0 = 1'b1; fiveMinTillArriv = 1'b1;
      cyc_exp(O_BUSY, "s1_prep_no_flow");
      fiveMinTillArriv = 1'b0;
      cyc_exp(O_C0, "s1_open_a");
      cyc_exp(O_C0, "s1_open_a_wait");
      doorOpen0 = 1'b1;
      cyc_exp(O_C0, "s1_enter");
      cyc_exp(O_C0, "s1_enter_wait");
      poundOccu = 1'b1;
      cyc_exp(O_BUSY, "s1_close_a");
      cyc_exp(O_BUSY, "s1_close_a_wait");
      doorOpen0 = 1'b0;
      repeat (5) cyc_exp(O_FILL, "s1_adjust_fill");
      diffOk1 = 1'b1;
      repeat (8) cyc_exp(O_BUSY, "s1_settle");
      cyc_exp(O_C1, "s1_open_b");
      cyc_exp(O_C1, "s1_open_b_wait");
      doorOpen1 = 1'b1;
      cyc_exp(O_C1, "s1_exit");
      poundOccu = 1'b0;
      cyc_exp(O_BUSY, "s1_close_b");
      cyc_exp(O_BUSY, "s1_close_b_wait");
      doorOpen1 = 1'b0;
      cyc_exp(O_IDLE, "s1_idle");
      quiet_inputs();

      // dir=1 with side 1 not level: PREP fills; dir change mid-transit ignored; ADJUST drains.
      dir = 1'b1; fiveMinTillArriv = 1'b1;
      cyc_exp(O_FILL, "s2_prep_fill");
      fiveMinTillArriv = 1'b0; dir = 1'b0;
      repeat (2) cyc_exp(O_FILL, "s2_prep_fill_hold");
      diffOk1 = 1'b1;
      cyc_exp(O_C1, "s2_open_a");
      doorOpen1 = 1'b1;
      cyc_exp(O_C1, "s2_enter");
      poundOccu = 1'b1;
      cyc_exp(O_BUSY, "s2_close_a");
      doorOpen1 = 1'b0;
      repeat (2) cyc_exp(O_DRAIN, "s2_adjust_drain");
      diffOk0 = 1'b1;
      repeat (8) cyc_exp(O_BUSY, "s2_settle");
      cyc_exp(O_C0, "s2_open_b");
      doorOpen0 = 1'b1;
      cyc_exp(O_C0, "s2_exit");
      poundOccu = 1'b0;
      cyc_exp(O_BUSY, "s2_close_b");
      doorOpen0 = 1'b0;
      cyc_exp(O_IDLE, "s2_idle");
      quiet_inputs();

      // Settle interrupted at count 5: back to ADJUST, full settle restarts.
      diffOk0 = 1'b1; fiveMinTillArriv = 1'b1;
      cyc_exp(O_BUSY, "s3_prep");
      fiveMinTillArriv = 1'b0;
      cyc_exp(O_C0, "s3_open_a");
      doorOpen0 = 1'b1;
      cyc_exp(O_C0, "s3_enter");
      poundOccu = 1'b1;
      cyc_exp(O_BUSY, "s3_close_a");
      doorOpen0 = 1'b0;
      cyc_exp(O_FILL, "s3_adjust");
      diffOk1 = 1'b1;
      repeat (6) cyc_exp(O_BUSY, "s3_settle_partial");
      diffOk1 = 1'b0;
      cyc_exp(O_FILL, "s3_readjust_fill");
      diffOk1 = 1'b1;
      repeat (8) cyc_exp(O_BUSY, "s3_settle_full");
      cyc_exp(O_C1, "s3_open_b");
      doorOpen1 = 1'b1;
      cyc_exp(O_C1, "s3_exit");
      poundOccu = 1'b0;
      cyc_exp(O_BUSY, "s3_close_b");
      doorOpen1 = 1'b0;
      cyc_exp(O_IDLE, "s3_idle");
      poundOccu = 1'b1; fiveMinTillArriv = 1'b1;
      repeat (2) cyc_exp(O_IDLE, "s3_occupied_ignored");
      quiet_inputs();

      // Ack on the limit cycle wins; then async reset while filling.
      diffOk0 = 1'b1; fiveMinTillArriv = 1'b1;
      cyc_exp(O_BUSY, "s4_prep");
      fiveMinTillArriv = 1'b0;
      cyc_exp(O_C0, "s4_open_a");
      repeat (15) cyc_exp(O_C0, "s4_open_a_wait");
      doorOpen0 = 1'b1;
      cyc_exp(O_C0, "s4_ack_at_limit");
      poundOccu = 1'b1;
      cyc_exp(O_BUSY, "s4_close_a");
      doorOpen0 = 1'b0;
      cyc_exp(O_FILL, "s4_adjust_fill");
      cyc_nc();
      reset = 1'b0;
      exp_now(O_IDLE, "s4_async_reset");
      quiet_inputs();
      cyc_exp(O_IDLE, "s4_reset_held");
      reset = 1'b1;
      cyc_exp(O_IDLE, "s4_after_reset");

      // Gate 0 never opens: fault exactly 16 cycles after OPEN_A, sticky until reset.
      diffOk0 = 1'b1; fiveMinTillArriv = 1'b1;
      cyc_exp(O_BUSY, "s5_prep");
      fiveMinTillArriv = 1'b0;
      cyc_exp(O_C0, "s5_open_a");
      repeat (15) cyc_exp(O_C0, "s5_open_a_wait");
      cyc_exp(O_FAULT, "s5_timeout");
      doorOpen0 = 1'b1; fiveMinTillArriv = 1'b1; diffOk1 = 1'b1;
      repeat (3) cyc_exp(O_FAULT, "s5_fault_sticky");
      cyc_nc();
      reset = 1'b0;
      exp_now(O_IDLE, "s5_reset_from_fault");
      quiet_inputs();
      cyc_exp(O_IDLE, "s5_reset_held");
      reset = 1'b1; diffOk0 = 1'b1; fiveMinTillArriv = 1'b1;
      cyc_exp(O_BUSY, "s5_resume_prep");
      fiveMinTillArriv = 1'b0;
      cyc_exp(O_C0, "s5_resume_open_a");

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expectations, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
